// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Run/pause/clear controller for a seconds counter. Edge-detected
//               button requests drive an IDLE/RUN/PAUSE FSM; while running, a
//               programmable tick divider advances a modulo-(CNT_MAX+1) count.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int WIDTH   = 6,
    parameter int CNT_MAX = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      num,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    input  logic             i_lap,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] lap,
    output logic             o_run,
    output logic             o_tick,
    output logic             o_wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_cnt_max = WIDTH'(CNT_MAX);

    // Button bit order inside the edge-detect vectors.
    localparam int c_b_start = 0;
    localparam int c_b_stop  = 1;
    localparam int c_b_clear = 2;
    localparam int c_b_lap   = 3;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_btn_q1;
    logic [3:0]       r_btn_q2;
    logic [3:0]       w_pulse;
    logic [31:0]      r_div_cnt;
    logic [31:0]      w_eff;
    logic             w_div_done;
    logic             w_advance;
    logic             w_tick;
    logic             w_at_max;
    logic             w_lap_take;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_lap;
    logic             r_run;
    logic             r_tick;
    logic             r_wrap;

    // Two-stage capture of the button levels; a pulse marks a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q1 <= '0;
            r_btn_q2 <= '0;
        end else begin
            r_btn_q1 <= {i_lap, i_clear, i_stop, i_start};
            r_btn_q2 <= r_btn_q1;
        end
    end

    assign w_pulse = r_btn_q1 & ~r_btn_q2;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: clear beats stop, stop beats start; inapplicable requests are dropped.
    always_comb begin
        w_state_nxt = r_state;
        if (w_pulse[c_b_clear]) begin
            w_state_nxt = IDLE;
        end else if (w_pulse[c_b_stop]) begin
            if (r_state == RUN) begin
                w_state_nxt = PAUSE;
            end
        end else if (w_pulse[c_b_start]) begin
            if (r_state != RUN) begin
                w_state_nxt = RUN;
            end
        end
    end

    // Divider terminal test uses >= so lowering num mid-period never stalls.
    assign w_eff      = (num == 32'd0) ? 32'd1 : num;
    assign w_div_done = (r_div_cnt >= (w_eff - 32'd1));
    assign w_advance  = (r_state == RUN) && !w_pulse[c_b_stop] && !w_pulse[c_b_clear];
    assign w_tick     = w_advance && w_div_done;
    assign w_at_max   = (r_out == c_cnt_max);
    assign w_lap_take = w_pulse[c_b_lap] && (r_state != IDLE);

    // Datapath: divider, seconds counter, lap capture and the output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_out     <= '0;
            r_lap     <= '0;
            r_run     <= 1'b0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_run  <= (w_state_nxt == RUN);
            r_tick <= w_tick;
            r_wrap <= w_tick && w_at_max;
            if (w_pulse[c_b_clear]) begin
                r_div_cnt <= '0;
                r_out     <= '0;
                r_lap     <= '0;
            end else begin
                if (w_advance) begin
                    r_div_cnt <= w_div_done ? 32'd0 : (r_div_cnt + 32'd1);
                end
                if (w_tick) begin
                    r_out <= w_at_max ? '0 : (r_out + 1'b1);
                end
                // Lap samples the pre-increment count.
                if (w_lap_take) begin
                    r_lap <= r_out;
                end
            end
        end
    end

    assign out    = r_out;
    assign lap    = r_lap;
    assign o_run  = r_run;
    assign o_tick = r_tick;
    assign o_wrap = r_wrap;

endmodule
`default_nettype wire
